// File: rtl/regfile_arb_pkg.sv
// Shared widths and types for the register-file write arbiter.
package regfile_arb_pkg;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int CNT_W = 8;
  typedef logic req_idx_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the pointer names the preferred requester on a tie.
import regfile_arb_pkg::*;

module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant,
  output req_idx_t   ptr
);

  req_idx_t ptr_q, ptr_d;

  always_comb begin
    grant = 2'b00;
    ptr_d = ptr_q;
    if (advance) begin
      if (valid == 2'b11) grant = ptr_q ? 2'b10 : 2'b01;
      else                grant = valid;
    end
    // After a grant, the loser becomes preferred.
    if (grant[0])      ptr_d = 1'b1;
    else if (grant[1]) ptr_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Arbitrates ALU and load writebacks onto one register-file write port,
// with RAW hazard flags and a saturating conflict counter.
import regfile_arb_pkg::*;

module regfile_wr_arbiter #(
  parameter int DW = regfile_arb_pkg::DW,
  parameter int AW = regfile_arb_pkg::AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  output logic          rf_we,
  output logic [AW-1:0] rf_wa,
  output logic [DW-1:0] rf_wd,
  input  logic [AW-1:0] rd_a1,
  input  logic [AW-1:0] rd_a2,
  output logic          hz1,
  output logic          hz2,
  output logic [7:0]    conflict_cnt
);

  logic [1:0]       valid, grant;
  logic             advance, accept;
  req_idx_t         sel, unused_ptr;
  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_data;

  logic             rf_we_q, rf_we_d;
  logic [AW-1:0]    rf_wa_q, rf_wa_d;
  logic [DW-1:0]    rf_wd_q, rf_wd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign valid   = {req1_valid, req0_valid};
  assign advance = rst_n && !stall;

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (valid),
    .advance (advance),
    .grant   (grant),
    .ptr     (unused_ptr)
  );

  always_comb begin
    accept   = |grant;
    sel      = req_idx_t'(grant[1]);
    sel_addr = sel ? req1_addr : req0_addr;
    sel_data = sel ? req1_data : req0_data;
    // x0 writes are acknowledged but never reach the register file.
    rf_we_d  = accept && (sel_addr != '0);
    rf_wa_d  = accept ? sel_addr : rf_wa_q;
    rf_wd_d  = accept ? sel_data : rf_wd_q;
    cnt_d    = cnt_q;
    if (valid == 2'b11 && advance && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_we_q <= 1'b0;
      rf_wa_q <= '0;
      rf_wd_q <= '0;
      cnt_q   <= '0;
    end else begin
      rf_we_q <= rf_we_d;
      rf_wa_q <= rf_wa_d;
      rf_wd_q <= rf_wd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req0_ready   = grant[0];
  assign req1_ready   = grant[1];
  assign rf_we        = rf_we_q;
  assign rf_wa        = rf_wa_q;
  assign rf_wd        = rf_wd_q;
  assign conflict_cnt = cnt_q;
  assign hz1          = rf_we_q && (rd_a1 == rf_wa_q) && (rd_a1 != '0);
  assign hz2          = rf_we_q && (rd_a2 == rf_wa_q) && (rd_a2 != '0);

endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 SHALL have parameter DW, 32, data width of a register write.
REQ-002 SHALL have parameter AW, 5, register address width (32 registers).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port stall  input  1  when high, blocks new grants.
REQ-006 SHALL have port req0_valid  input  1  requester 0 (ALU writeback) has a write pending.
REQ-007 SHALL have port req0_addr  input  AW  requester 0 destination register.
REQ-008 SHALL have port req0_data  input  DW  requester 0 write data.
REQ-009 SHALL have port req0_ready  output  1  requester 0 write accepted this cycle.
REQ-010 SHALL have ports req1_valid, req1_addr, req1_data, req1_ready with the same widths and meanings for requester 1 (load writeback).
REQ-011 SHALL have port rf_we  output  1  register-file write enable.
REQ-012 SHALL have port rf_wa  output  AW  register-file write address.
REQ-013 SHALL have port rf_wd  output  DW  register-file write data.
REQ-014 SHALL have ports rd_a1, rd_a2  input  AW  current register-file read addresses.
REQ-015 SHALL have ports hz1, hz2  output  1  read-after-write hazard flags for rd_a1 and rd_a2.
REQ-016 SHALL have port conflict_cnt  output  8  saturating count of deferred-request cycles.

Function
REQ-017 SHALL accept a transfer on requester i when reqi_valid and reqi_ready are both high in the same cycle.
REQ-018 SHALL drive req0_ready and req1_ready combinationally, assert at most one per cycle, and assert neither while stall is high.
REQ-019 SHALL grant the only valid requester when exactly one reqi_valid is high.
REQ-020 SHALL grant the requester selected by a 1-bit round-robin pointer when both are valid.
REQ-021 SHALL set the pointer to the non-granted requester after every grant, and hold it when there is no grant.
REQ-022 SHALL expect a requester to hold valid, addr and data stable until ready; behaviour under a violation is unspecified.
REQ-023 SHALL register an accepted write: in the next cycle rf_wa = addr and rf_wd = data (1-cycle latency).
REQ-024 SHALL drive rf_we high in that cycle only if the accepted addr is nonzero; writes to x0 are acknowledged but suppressed.
REQ-025 SHALL drive rf_we low in any cycle following a cycle with no accepted write; rf_wa and rf_wd then hold their previous values.
REQ-026 SHALL drive hz1 = rf_we && (rd_a1 == rf_wa) && (rd_a1 != 0), combinationally; hz2 likewise for rd_a2.
REQ-027 SHALL increment conflict_cnt in each cycle where both requesters are valid, stall is low and one is deferred, saturating at 255.
REQ-028 SHALL, when both requesters target the same address, commit the granted write first and the other write in a later cycle, so the last grant determines the final register value.
REQ-029 SHALL accept at most one write per cycle, sustaining one write per cycle under continuous requests.

Reset
REQ-030 SHALL, when rst_n is low at a clock edge, set rf_we=0, rf_wa=0, rf_wd=0, pointer=0 (requester 0 preferred) and conflict_cnt=0.
REQ-031 SHALL force req0_ready=0 and req1_ready=0 while rst_n is low.
REQ-032 SHALL discard any write accepted in the cycle reset is applied, so that rf_we=0 in the following cycle.

Structure
REQ-033 SHALL take DW, AW and a requester-index typedef (req_idx_t, 1 bit) from the shared package regfile_arb_pkg.
REQ-034 SHALL implement the pointer and grant logic in one sub-module, rr_arb2, which takes valid[1:0] and advance, and returns grant[1:0] and the pointer.

Verification
REQ-035 SHALL cover: after reset, req0 only, addr=3, data=0x0F -> req0_ready=1 that cycle; next cycle rf_we=1, rf_wa=3, rf_wd=0x0000000F.
REQ-036 SHALL cover: after reset, both valid (r0 addr=5 data=0xA, r1 addr=6 data=0xB) -> cycle0 grant r0, cycle1 grant r1; rf writes 5 then 6; conflict_cnt=1.
REQ-037 SHALL cover: req1 addr=0, data=0xFFFFFFFF -> req1_ready=1; next cycle rf_we=0.
REQ-038 SHALL cover: both valid with pointer=1 and stall=1 for 2 cycles -> no ready and conflict_cnt unchanged; on stall=0, r1 is granted first.
REQ-039 SHALL cover: write to 7 committed, rd_a1=7, rd_a2=0 -> hz1=1, hz2=0 in the rf_we cycle; both 0 in the following idle cycle.
REQ-040 SHALL cover: both valid continuously for 300 cycles -> grants alternate every cycle; conflict_cnt saturates at 255; rst_n=0 mid-run -> next cycle rf_we=0 and conflict_cnt=0.
